// File: rtl/dac_ad53x8_rx.sv
// AD53x8 SPI responder: deserialises 16-bit frames, writes channel input
// registers and transfers them to DAC registers while ldac_n is low.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   spi_sclk_i      SPI clock (idle low), asynchronous
//   spi_cs_n_i      chip select, active low, asynchronous
//   spi_mosi_i      serial data, MSB first, changes on sclk rise
//   ldac_n_i        load DAC, active low, level-sensitive, asynchronous
//   rx_word_o       last complete frame
//   rx_valid_o      one-cycle strobe, rx_word_o updated
//   ctrl_valid_o    one-cycle strobe, received word had bit15 set
//   frame_err_o     one-cycle strobe, short frame or overrun
//   busy_o          frame in progress
//   in_regs_o       input registers, channel 0 at LSBs
//   dac_regs_o      DAC registers, channel 0 at LSBs
module dac_ad53x8_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 8,
    parameter int DAC_BITS   = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_sclk_i,
    input  logic                         spi_cs_n_i,
    input  logic                         spi_mosi_i,
    input  logic                         ldac_n_i,
    output logic [DATA_WIDTH-1:0]        rx_word_o,
    output logic                         rx_valid_o,
    output logic                         ctrl_valid_o,
    output logic                         frame_err_o,
    output logic                         busy_o,
    output logic [NUM_CH*DAC_BITS-1:0]   in_regs_o,
    output logic [NUM_CH*DAC_BITS-1:0]   dac_regs_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    state_e state_q, state_d;

    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] cs_sync_q, cs_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [1:0] ldac_sync_q, ldac_sync_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  ovr_q, ovr_d;
    logic                  dec_q, dec_d;

    logic [DATA_WIDTH-1:0] rx_word_q, rx_word_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  ctrl_valid_q, ctrl_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic [NUM_CH-1:0][DAC_BITS-1:0] in_regs_q, in_regs_d;
    logic [NUM_CH-1:0][DAC_BITS-1:0] dac_regs_q, dac_regs_d;

    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic cs_high;
    logic mosi_bit;
    logic ldac_low;
    logic last_bit;

    // Stage [1] is the synchronised level; stage [2] is its previous value.
    // mosi stage [1] has the same depth as sclk stage [1].
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_high   = cs_sync_q[1];
    assign mosi_bit  = mosi_sync_q[1];
    assign ldac_low  = ~ldac_sync_q[1];
    assign last_bit  = (cnt_q == CW'(DATA_WIDTH - 1));

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk_i};
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n_i};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi_i};
        ldac_sync_d = {ldac_sync_q[0], ldac_n_i};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ovr_d       = ovr_q;
        dec_d       = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            WAIT_IDLE: begin
                if (cs_high) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    ovr_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The final capture beats a simultaneous cs_n rise.
                if (sclk_fall && last_bit) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], mosi_bit};
                    cnt_d   = cnt_q + 1'b1;
                    dec_d   = 1'b1;
                    state_d = HOLD;
                end else if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (sclk_fall) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], mosi_bit};
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Leave on cs_n level so a rise consumed by the final
                // capture still returns us to IDLE.
                if (sclk_fall) ovr_d = 1'b1;
                if (cs_high) begin
                    frame_err_d = ovr_q | sclk_fall;
                    ovr_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        rx_valid_d   = dec_q;
        ctrl_valid_d = dec_q & shreg_q[DATA_WIDTH-1];
        rx_word_d    = dec_q ? shreg_q : rx_word_q;
        in_regs_d    = in_regs_q;
        if (dec_q && !shreg_q[DATA_WIDTH-1]) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(shreg_q[14:12]) == i) begin
                    in_regs_d[i] = shreg_q[11 -: DAC_BITS];
                end
            end
        end
        dac_regs_d = ldac_low ? in_regs_d : dac_regs_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WAIT_IDLE;
            sclk_sync_q  <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            ldac_sync_q  <= '1;
            cnt_q        <= '0;
            shreg_q      <= '0;
            ovr_q        <= 1'b0;
            dec_q        <= 1'b0;
            rx_word_q    <= '0;
            rx_valid_q   <= 1'b0;
            ctrl_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            in_regs_q    <= '0;
            dac_regs_q   <= '0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            ldac_sync_q  <= ldac_sync_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            ovr_q        <= ovr_d;
            dec_q        <= dec_d;
            rx_word_q    <= rx_word_d;
            rx_valid_q   <= rx_valid_d;
            ctrl_valid_q <= ctrl_valid_d;
            frame_err_q  <= frame_err_d;
            in_regs_q    <= in_regs_d;
            dac_regs_q   <= dac_regs_d;
        end
    end

    assign rx_word_o    = rx_word_q;
    assign rx_valid_o   = rx_valid_q;
    assign ctrl_valid_o = ctrl_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q == SHIFT) || (state_q == HOLD);
    assign in_regs_o    = in_regs_q;
    assign dac_regs_o   = dac_regs_q;

endmodule

// File: tb/tb_dac_ad53x8_rx.sv
// Testbench for dac_ad53x8_rx: drives SPI frames as a master at clk/4
// and compares strobes and registers against a channel-array model.
module tb_dac_ad53x8_rx;

    logic        clk;
    logic        rst_n;
    logic        spi_sclk_i;
    logic        spi_cs_n_i;
    logic        spi_mosi_i;
    logic        ldac_n_i;
    logic [15:0] rx_word_o;
    logic        rx_valid_o;
    logic        ctrl_valid_o;
    logic        frame_err_o;
    logic        busy_o;
    logic [95:0] in_regs_o;
    logic [95:0] dac_regs_o;

    dac_ad53x8_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk_i   (spi_sclk_i),
        .spi_cs_n_i   (spi_cs_n_i),
        .spi_mosi_i   (spi_mosi_i),
        .ldac_n_i     (ldac_n_i),
        .rx_word_o    (rx_word_o),
        .rx_valid_o   (rx_valid_o),
        .ctrl_valid_o (ctrl_valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o),
        .in_regs_o    (in_regs_o),
        .dac_regs_o   (dac_regs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observed strobe history
    int          cyc = 0;
    int          rx_cnt = 0;
    int          ctrl_cnt = 0;
    int          err_cnt = 0;
    int          rv_cyc = 0;
    int          fall_cyc = 0;
    logic [15:0] last_word = '0;
    logic [95:0] snap_in = '0;
    logic [95:0] snap_dac = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid_o) begin
            rx_cnt    = rx_cnt + 1;
            rv_cyc    = cyc;
            last_word = rx_word_o;
            snap_in   = in_regs_o;
            snap_dac  = dac_regs_o;
        end
        if (ctrl_valid_o) ctrl_cnt = ctrl_cnt + 1;
        if (frame_err_o) err_cnt = err_cnt + 1;
    end

    // Reference model: one entry per channel
    logic [11:0] m_in  [8];
    logic [11:0] m_dac [8];

    function automatic logic [95:0] pack(input logic [11:0] a [8]);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*12 +: 12] = a[i];
        return r;
    endfunction

    // A complete DAC write stores the 12-bit value in its channel.
    task automatic model_word(input logic [15:0] w);
        if (!w[15]) m_in[int'(w[14:12])] = w[11:0];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_in[i]  = '0;
            m_dac[i] = '0;
        end
    endtask

    task automatic model_load();
        for (int i = 0; i < 8; i++) m_dac[i] = m_in[i];
    endtask

    // Clock bits [first, first+nb) of w; bits past 15 are random.
    task automatic spi_bits(input logic [15:0] w, input int first, input int nb);
        for (int i = first; i < first + nb; i++) begin
            if (i < 16) spi_mosi_i = w[15-i];
            else spi_mosi_i = 1'($urandom & 1);
            spi_sclk_i = 1'b1;
            repeat (2) @(negedge clk);
            spi_sclk_i = 1'b0;
            if (i == 15) fall_cyc = cyc;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nb);
        spi_cs_n_i = 1'b0;
        repeat (2) @(negedge clk);
        spi_bits(w, 0, nb);
        spi_cs_n_i = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_ldac();
        ldac_n_i = 1'b0;
        repeat (3) @(negedge clk);
        ldac_n_i = 1'b1;
        repeat (4) @(negedge clk);
        model_load();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (rx_word_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_rx_word got=%h exp=0000", rx_word_o);
        end
        checks++;
        if ({rx_valid_o, ctrl_valid_o, frame_err_o, busy_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {rx_valid_o, ctrl_valid_o, frame_err_o, busy_o});
        end
        checks++;
        if (in_regs_o !== 96'h0) begin
            errors++;
            $display("FAIL reset_in_regs got=%h exp=0", in_regs_o);
        end
        checks++;
        if (dac_regs_o !== 96'h0) begin
            errors++;
            $display("FAIL reset_dac_regs got=%h exp=0", dac_regs_o);
        end
    endtask

    task automatic test_ldac_pulse();
        int rx0;
        rx0 = rx_cnt;
        spi_frame(16'h2ABC, 16);
        model_word(16'h2ABC);
        checks++;
        if (rx_cnt - rx0 != 1) begin
            errors++;
            $display("FAIL ldacp_rx_count got=%0d exp=1", rx_cnt - rx0);
        end
        checks++;
        if (rv_cyc - fall_cyc != 4) begin
            errors++;
            $display("FAIL latency got=%0d exp=4", rv_cyc - fall_cyc);
        end
        checks++;
        if (snap_in[2*12 +: 12] !== 12'hABC) begin
            errors++;
            $display("FAIL ldacp_in_ch2 got=%h exp=abc", snap_in[2*12 +: 12]);
        end
        checks++;
        if (dac_regs_o !== pack(m_dac)) begin
            errors++;
            $display("FAIL ldacp_dac_hold got=%h exp=%h", dac_regs_o, pack(m_dac));
        end
        pulse_ldac();
        checks++;
        if (dac_regs_o !== pack(m_dac)) begin
            errors++;
            $display("FAIL ldacp_dac_load got=%h exp=%h", dac_regs_o, pack(m_dac));
        end
    endtask

    task automatic test_ldac_low();
        ldac_n_i = 1'b0;
        repeat (4) @(negedge clk);
        model_load();
        spi_frame(16'h7FFF, 16);
        model_word(16'h7FFF);
        model_load();
        ldac_n_i = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (last_word !== 16'h7FFF) begin
            errors++;
            $display("FAIL ldacl_rx_word got=%h exp=7fff", last_word);
        end
        checks++;
        if (snap_in[7*12 +: 12] !== 12'hFFF || snap_dac[7*12 +: 12] !== 12'hFFF) begin
            errors++;
            $display("FAIL ldacl_same_cycle in=%h dac=%h exp=fff",
                     snap_in[7*12 +: 12], snap_dac[7*12 +: 12]);
        end
        checks++;
        if (dac_regs_o !== pack(m_dac)) begin
            errors++;
            $display("FAIL ldacl_dac got=%h exp=%h", dac_regs_o, pack(m_dac));
        end
    endtask

    task automatic test_ctrl();
        int rx0, c0;
        rx0 = rx_cnt;
        c0  = ctrl_cnt;
        spi_frame(16'h9000, 16);
        model_word(16'h9000);
        checks++;
        if (rx_cnt - rx0 != 1 || ctrl_cnt - c0 != 1) begin
            errors++;
            $display("FAIL ctrl_strobes rx=%0d ctrl=%0d exp=1,1",
                     rx_cnt - rx0, ctrl_cnt - c0);
        end
        checks++;
        if (last_word !== 16'h9000) begin
            errors++;
            $display("FAIL ctrl_rx_word got=%h exp=9000", last_word);
        end
        checks++;
        if (in_regs_o !== pack(m_in) || dac_regs_o !== pack(m_dac)) begin
            errors++;
            $display("FAIL ctrl_regs in=%h dac=%h exp in=%h dac=%h",
                     in_regs_o, dac_regs_o, pack(m_in), pack(m_dac));
        end
    endtask

    task automatic test_short_frame();
        int rx0, e0;
        rx0 = rx_cnt;
        e0  = err_cnt;
        spi_frame(16'($urandom), 10);
        checks++;
        if (err_cnt - e0 != 1 || rx_cnt - rx0 != 0) begin
            errors++;
            $display("FAIL short_strobes err=%0d rx=%0d exp=1,0",
                     err_cnt - e0, rx_cnt - rx0);
        end
        checks++;
        if (in_regs_o !== pack(m_in)) begin
            errors++;
            $display("FAIL short_regs got=%h exp=%h", in_regs_o, pack(m_in));
        end
        rx0 = rx_cnt;
        e0  = err_cnt;
        spi_frame(16'h1123, 16);
        model_word(16'h1123);
        checks++;
        if (err_cnt - e0 != 0 || rx_cnt - rx0 != 1) begin
            errors++;
            $display("FAIL after_short_strobes err=%0d rx=%0d exp=0,1",
                     err_cnt - e0, rx_cnt - rx0);
        end
        checks++;
        if (in_regs_o !== pack(m_in)) begin
            errors++;
            $display("FAIL after_short_regs got=%h exp=%h", in_regs_o, pack(m_in));
        end
    endtask

    task automatic test_overrun();
        int rx0, e0;
        rx0 = rx_cnt;
        e0  = err_cnt;
        spi_frame(16'h3456, 18);
        model_word(16'h3456);
        checks++;
        if (snap_in[3*12 +: 12] !== 12'h456 || last_word !== 16'h3456) begin
            errors++;
            $display("FAIL ovr_decode ch3=%h word=%h exp=456,3456",
                     snap_in[3*12 +: 12], last_word);
        end
        checks++;
        if (err_cnt - e0 != 1 || rx_cnt - rx0 != 1) begin
            errors++;
            $display("FAIL ovr_strobes err=%0d rx=%0d exp=1,1",
                     err_cnt - e0, rx_cnt - rx0);
        end
    endtask

    task automatic test_back_to_back();
        int          rx0, e0, c0, exp_c;
        logic [15:0] w;
        rx0   = rx_cnt;
        e0    = err_cnt;
        exp_c = ctrl_cnt;
        for (int n = 0; n < 8; n++) begin
            w = 16'($urandom);
            c0 = ctrl_cnt;
            spi_frame(w, 16);
            model_word(w);
            if (w[15]) exp_c++;
            checks++;
            if (last_word !== w || in_regs_o !== pack(m_in)) begin
                errors++;
                $display("FAIL b2b_%0d word=%h exp=%h in=%h exp=%h",
                         n, last_word, w, in_regs_o, pack(m_in));
            end
            checks++;
            if (ctrl_cnt - c0 != int'(w[15])) begin
                errors++;
                $display("FAIL b2b_ctrl_%0d got=%0d exp=%0d",
                         n, ctrl_cnt - c0, int'(w[15]));
            end
        end
        checks++;
        if (rx_cnt - rx0 != 8 || err_cnt - e0 != 0 || ctrl_cnt != exp_c) begin
            errors++;
            $display("FAIL b2b_totals rx=%0d err=%0d exp=8,0",
                     rx_cnt - rx0, err_cnt - e0);
        end
        pulse_ldac();
        checks++;
        if (dac_regs_o !== pack(m_dac)) begin
            errors++;
            $display("FAIL b2b_dac got=%h exp=%h", dac_regs_o, pack(m_dac));
        end
    endtask

    task automatic test_reset_midframe();
        int rx0, e0, c0;
        spi_cs_n_i = 1'b0;
        repeat (2) @(negedge clk);
        spi_bits(16'h5777, 0, 8);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy got=%b exp=1", busy_o);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        rx0 = rx_cnt;
        e0  = err_cnt;
        c0  = ctrl_cnt;
        spi_bits(16'h5777, 8, 8);
        spi_cs_n_i = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (rx_cnt != rx0 || err_cnt != e0 || ctrl_cnt != c0) begin
            errors++;
            $display("FAIL midrst_strobes rx=%0d err=%0d ctrl=%0d exp=0,0,0",
                     rx_cnt - rx0, err_cnt - e0, ctrl_cnt - c0);
        end
        checks++;
        if (in_regs_o !== pack(m_in)) begin
            errors++;
            $display("FAIL midrst_regs got=%h exp=%h", in_regs_o, pack(m_in));
        end
        spi_frame(16'h0001, 16);
        model_word(16'h0001);
        checks++;
        if (rx_cnt - rx0 != 1 || in_regs_o !== pack(m_in)) begin
            errors++;
            $display("FAIL midrst_next rx=%0d in=%h exp=1,%h",
                     rx_cnt - rx0, in_regs_o, pack(m_in));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        spi_sclk_i = 1'b0;
        spi_cs_n_i = 1'b1;
        spi_mosi_i = 1'b0;
        ldac_n_i   = 1'b1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_ldac_pulse();
        test_ldac_low();
        test_ctrl();
        test_short_frame();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_ad53x8_rx.md
Name: dac_ad53x8_rx

Overview:
- SPI responder for the AD53x8 frame format: the device end of the link our DAC SPI masters drive.
- Samples sclk/cs_n/mosi from an external master, deserialises DATA_WIDTH-bit MSB-first frames and decodes DAC write words into per-channel input registers.
- Transfers input registers to DAC registers under ldac_n_i.
- Used as an on-chip DAC model for loopback self-test and as a bench responder for DAC master blocks.

Parameters:
- DATA_WIDTH, 16, SPI frame length in bits (fixed AD53x8 word; must be 16).
- NUM_CH, 8, number of DAC channels (address field word[14:12]).
- DAC_BITS, 12, channel resolution (8/10/12); value = word[11 -: DAC_BITS].

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- spi_sclk_i  in  1  SPI clock, idle low, asynchronous to clk
- spi_cs_n_i  in  1  chip select, active low, asynchronous
- spi_mosi_i  in  1  serial data, MSB first, changes on sclk rise
- ldac_n_i  in  1  load DAC, active low, asynchronous
- rx_word_o  out  DATA_WIDTH  last complete frame
- rx_valid_o  out  1  one-cycle strobe, rx_word_o updated
- ctrl_valid_o  out  1  one-cycle strobe, received word had bit15=1
- frame_err_o  out  1  one-cycle strobe, malformed frame
- busy_o  out  1  frame in progress (cs_n low, state SHIFT/HOLD)
- in_regs_o  out  NUM_CH*DAC_BITS  input registers, channel 0 at LSBs
- dac_regs_o  out  NUM_CH*DAC_BITS  DAC (output) registers, channel 0 at LSBs

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk.
- Reset values: all outputs 0; in_regs/dac_regs 0; state WAIT_IDLE.
- Synchronisation:
  - sclk, cs_n, mosi and ldac_n each pass through a 2-flop synchroniser; sclk and cs_n get a third stage for edge detection.
  - Requires f_clk >= 4*f_sclk.
  - mosi is sampled at the detected sclk falling edge. Its pipeline is equal in depth to sclk's, so the sampled bit is the one present at the pin edge.
- FSM states:
  - WAIT_IDLE: entered from reset. Goes to IDLE only once synced cs_n is observed high. A frame already in progress at reset release is ignored entirely.
  - IDLE: on cs_n falling edge, clear bit counter and shift register, then go to SHIFT. sclk edges while cs_n is high are ignored.
  - SHIFT: on each sclk falling edge, shift the register left and insert mosi; increment the counter (width clog2(DATA_WIDTH+1)).
    - When the DATA_WIDTH-th bit is captured, go to HOLD; the word is decoded in the next cycle.
    - A cs_n rising edge with counter < DATA_WIDTH produces a frame_err_o pulse, discards the word and returns to IDLE.
  - HOLD: wait for the cs_n rising edge, then go to IDLE.
    - Further sclk falling edges set a sticky overrun flag. At the cs_n rise, overrun produces a frame_err_o pulse.
    - The already-decoded word is not revoked.
- Decode (one cycle after the 16th capture):
  - rx_word_o is loaded and rx_valid_o is pulsed.
  - If word[15]=0: in_regs[word[14:12]] <= word[11 -: DAC_BITS].
  - If word[15]=1: pulse ctrl_valid_o; registers are unchanged.
  - If word[14:12] >= NUM_CH: the write is dropped, but rx_valid_o still pulses.
- LDAC (level-sensitive):
  - While synced ldac_n is low, every cycle dac_regs <= next-state in_regs (write-through).
  - A write decoded in a cycle where ldac_n is low updates in_regs and dac_regs in the same cycle.
  - While ldac_n is high, dac_regs hold.
- Latency: pin sclk fall of bit 16 to rx_valid_o = 4 clk cycles (2 sync + 1 edge detect + 1 decode).
- Simultaneous events: a cs_n rise in the same clk as the 16th sclk fall is treated as a complete frame. The capture wins, followed by HOLD→IDLE in the next cycle; no frame_err_o.
- Reset mid-frame: state goes to WAIT_IDLE, partial data is lost and no strobes are issued.

Test Plan:
- Frame 0x2ABC (ch2, data 0xABC) with ldac_n high, then ldac_n pulsed low for 3 clk → in_regs ch2=0xABC after rx_valid; dac_regs ch2 stays 0 until ldac_n low, then 0xABC.
- ldac_n held low, frame 0x7FFF → in_regs and dac_regs ch7 both =0xFFF in the same cycle; rx_word_o=0x7FFF.
- Frame 0x9000 (bit15=1) → ctrl_valid_o=1, rx_valid_o=1, no register changes.
- cs_n raised after 10 bits → frame_err_o pulse, no rx_valid_o, registers unchanged; the next full frame 0x1123 is accepted (ch1=0x123).
- 18 sclk pulses carrying 0x3456 followed by 2 extra bits → ch3=0x456 at the 16th bit, frame_err_o pulse at the cs_n rise.
- rst_n asserted after 8 bits of a frame while cs_n is low; released with cs_n still low and the remaining 8 bits clocked → no strobe, no write. The next cs_n-framed 0x0001 gives ch0=0x001.
- Back-to-back frames with a 5-cycle cs_n high gap at f_sclk=clk/4 → every frame decoded, no frame_err_o.
